// File: rtl/instr_encoder.sv
// MIPS32 instruction encoder: combinational encode into a 2-entry {instr, illegal} FIFO.
// Optional build macro INSTR_ENC_J_EN enables encoding of in_op 9 (j); otherwise it is illegal.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_illegal,
  output logic [15:0] instr_cnt
);

  localparam int DATA_W = 32;

  // Returns {illegal, instr}; illegal mnemonics encode as an all-zero word.
  function automatic logic [DATA_W:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [DATA_W-1:0] instr;
    logic              illegal;
    instr   = '0;
    illegal = 1'b0;
    case (op)
      4'd0: instr = {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
      4'd1: instr = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
      4'd2: instr = {6'b001101, rs, rt, imm};
      4'd3: instr = {6'b100011, rs, rt, imm};
      4'd4: instr = {6'b101011, rs, rt, imm};
      4'd5: instr = {6'b000100, rs, rt, imm};
      4'd6: instr = {6'b001111, 5'b00000, rt, imm};
      4'd7: instr = {6'b000011, target};
      4'd8: instr = {6'b000000, rs, 15'd0, 6'b001000};
`ifdef INSTR_ENC_J_EN
      4'd9: instr = {6'b000010, target};
`endif
      default: begin
        instr   = '0;
        illegal = 1'b1;
      end
    endcase
    return {illegal, instr};
  endfunction

  // Stage p0: combinational encode of the incoming request
  logic [DATA_W:0] enc_p0;
  logic            push;
  logic            pop;

  always_comb begin
    enc_p0 = encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
  end

  // Stage p1: 2-entry FIFO storage and control
  logic [DATA_W:0] mem_p1 [2];
  logic            wr_ptr_p1;
  logic            rd_ptr_p1;
  logic [1:0]      count_p1;
  logic [DATA_W:0] head_p1;

  assign in_ready  = ~reset & (count_p1 != 2'd2);
  assign out_valid = (count_p1 != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head_p1   = mem_p1[rd_ptr_p1];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_p1[wr_ptr_p1] <= enc_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
      count_p1  <= 2'd0;
      instr_cnt <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr_p1 <= ~wr_ptr_p1;
      end
      if (pop) begin
        rd_ptr_p1 <= ~rd_ptr_p1;
        if (!head_p1[DATA_W]) begin
          instr_cnt <= instr_cnt + 16'd1;
        end
      end
      case ({push, pop})
        2'b10:   count_p1 <= count_p1 + 2'd1;
        2'b01:   count_p1 <= count_p1 - 2'd1;
        default: count_p1 <= count_p1;
      endcase
    end
  end

  // Output stage: head is masked to zero when the FIFO is empty
  assign out_instr   = out_valid ? head_p1[DATA_W-1:0] : '0;
  assign out_illegal = out_valid & head_p1[DATA_W];

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  encoder can accept a request this cycle.
REQ-006 in_op  in  4  mnemonic: 0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 jal, 8 jr, 9 j; 10-15 illegal.
REQ-007 in_rs, in_rt, in_rd  in  5 each  register fields.
REQ-008 in_imm  in  16  immediate/offset field.
REQ-009 in_target  in  26  jump target field.
REQ-010 out_valid  out  1  encoded word available.
REQ-011 out_ready  in  1  consumer takes word this cycle.
REQ-012 out_instr  out  32  encoded MIPS32 instruction word.
REQ-013 out_illegal  out  1  word at head came from an illegal in_op.
REQ-014 instr_cnt  out  16  count of legal words delivered.

Function
REQ-015 Transfer in: in_valid & in_ready at a rising edge; transfer out: out_valid & out_ready at a rising edge.
REQ-016 Encoding SHALL be computed combinationally at input and stored in a 2-entry FIFO of {instr[31:0], illegal}.
REQ-017 R-type addu/subu: opc 000000, rs, rt, rd, shamt 00000, func 100001/100011.
REQ-018 jr: opc 000000, rs, rt=0, rd=0, shamt=0, func 001000.
REQ-019 ori 001101, lw 100011, sw 101011, beq 000100: {opc, rs, rt, imm}.
REQ-020 lui: {001111, 00000, rt, imm}; in_rs ignored.
REQ-021 jal 000011, j 000010: {opc, target}.
REQ-022 Illegal in_op: entry accepted, instr = 0x00000000, illegal = 1.
REQ-023 in_ready = 1 iff FIFO holds fewer than 2 entries; independent of out_ready.
REQ-024 out_valid = 1 iff FIFO non-empty; out_instr/out_illegal reflect head entry, held stable while out_valid & ~out_ready.
REQ-025 Latency: word accepted at edge N, FIFO empty before, SHALL show out_valid at cycle after edge N (one cycle).
REQ-026 Simultaneous push and pop with 1 entry: occupancy stays 1; new word becomes head next cycle.
REQ-027 Full (2 entries): no push; pop frees a slot, in_ready high next cycle.
REQ-028 Empty: out_ready ignored; no pop, no count change.
REQ-029 Order SHALL be strictly FIFO; pointers wrap modulo 2.
REQ-030 instr_cnt increments by 1 on each out transfer with illegal=0; wraps 0xFFFF -> 0x0000.

Reset
REQ-031 On reset: FIFO empty, pointers 0, out_valid 0, in_ready 1 (after reset), out_instr 0x00000000, out_illegal 0, instr_cnt 0.
REQ-032 in_ready SHALL be 0 while reset is asserted.
REQ-033 Reset mid-operation: pending entries discarded immediately; no transfer counted in reset cycle.

Configuration
REQ-034 Macro INSTR_ENC_J_EN: defined -> in_op 9 encodes j per REQ-021; undefined -> in_op 9 treated as illegal per REQ-022; all else identical.

Verification
REQ-035 Reset, in_op=0 rs=1 rt=2 rd=3, out_ready=1 -> next cycle out_instr 0x00221821, out_illegal 0, instr_cnt 1 after transfer.
REQ-036 lui rt=8 imm=0x1234 (rs=5), ori rs=8 rt=8 imm=0x5678 -> 0x3C081234, 0x35085678 in order.
REQ-037 out_ready=0, push 3 requests -> in_ready 0 after 2 accepted; release out_ready -> words 1,2 emitted in order, third accepted when slot frees.
REQ-038 in_op=12 -> out_instr 0x00000000, out_illegal 1, instr_cnt unchanged; in_op=9 target 0x0000100 -> 0x08000100 with INSTR_ENC_J_EN, illegal without.
REQ-039 jal target 0x0000C00 then jr rs=31 -> 0x0C000C00, 0x03E00008; preload instr_cnt 0xFFFF via 65535 legal words -> next legal word wraps to 0x0000.
REQ-040 Reset asserted with 2 entries held -> out_valid 0, instr_cnt 0 immediately; no stale word emitted after release.
